// File: rtl/pulse_issue_queue.sv
// rtl/pulse_issue_queue.sv - decodes quantum pulse/barrier instructions into per-channel issue FIFOs
// Barriers stall decode until every channel queue has drained.
module pulse_issue_queue #(
   parameter int         NUM_CH  = 4,
   parameter int         DEPTH   = 4,
   parameter logic [6:0] QOPCODE = 7'b0001011
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           in_instr,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [32*NUM_CH-1:0]  out_instr,
   output logic [NUM_CH-1:0]     out_valid,
   input  logic [NUM_CH-1:0]     out_ready,
   output logic                  drain_busy,
   output logic                  err_bad_ch,
   output logic [15:0]           issued_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {S_IDLE, S_DRAIN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [4:0]          w_ch;
   logic                w_is_pulse;
   logic                w_is_barrier;
   logic                w_ch_ok;
   logic                w_sel_full;
   logic                w_all_empty;
   logic                w_push_en;
   logic                w_bad_hs;
   logic [NUM_CH-1:0]   w_full;
   logic [NUM_CH-1:0]   w_pop;
   logic [15:0]         w_pop_n;

   assign w_ch         = in_instr[19:15];
   assign w_is_pulse   = (in_instr[6:0] == QOPCODE) && (in_instr[14:12] == 3'b000);
   assign w_is_barrier = (in_instr[6:0] == QOPCODE) && (in_instr[14:12] == 3'b001);
   assign w_ch_ok      = 32'(w_ch) < NUM_CH;
   assign w_all_empty  = ~|out_valid;
   assign w_pop        = out_valid & out_ready;
   assign drain_busy   = (r_state == S_DRAIN);

   always_comb begin
      w_sel_full = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_ch == 5'(c)) w_sel_full = w_full[c];
      end
   end

   always_comb begin
      w_pop_n = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_pop_n = w_pop_n + 16'(w_pop[c]);
      end
   end

   // Readiness uses registered counts only, so a full channel stays stalled even while popping.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_push_en   = 1'b0;
      w_bad_hs    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_is_pulse) begin
               if (w_ch_ok) begin
                  in_ready  = !w_sel_full;
                  w_push_en = in_valid && !w_sel_full;
               end else begin
                  in_ready = 1'b1;
                  w_bad_hs = in_valid;
               end
            end else if (w_is_barrier) begin
               in_ready = w_all_empty;
               if (in_valid && !w_all_empty) w_state_nxt = S_DRAIN;
            end else begin
               in_ready = 1'b1;
            end
         end
         S_DRAIN: begin
            if (w_all_empty) begin
               in_ready    = in_valid;
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         err_bad_ch <= 1'b0;
         issued_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         issued_cnt <= issued_cnt + w_pop_n;
         if (w_bad_hs) err_bad_ch <= 1'b1;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PW-1:0] r_wr_ptr;
      logic [PW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      logic [31:0]   r_mem [DEPTH];
      logic          w_push;

      assign w_push                 = w_push_en && (w_ch == 5'(c));
      assign w_full[c]              = (r_count == CW'(DEPTH));
      assign out_valid[c]           = (r_count != '0);
      assign out_instr[32*c +: 32]  = out_valid[c] ? r_mem[r_rd_ptr] : 32'h0;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop[c]) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop[c]})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wr_ptr] <= in_instr;
      end
   end

endmodule

// File: tb/tb_pulse_issue_queue.sv
// tb/tb_pulse_issue_queue.sv - queue-model checker for pulse_issue_queue
module tb_pulse_issue_queue;

   localparam int         NCH = 4;
   localparam int         DEP = 4;
   localparam logic [6:0] QOP = 7'b0001011;
   localparam logic [31:0] BAR = 32'h0000_100B;

   logic                clk = 1'b0;
   logic                reset;
   logic [31:0]         in_instr;
   logic                in_valid;
   logic                in_ready;
   logic [32*NCH-1:0]   out_instr;
   logic [NCH-1:0]      out_valid;
   logic [NCH-1:0]      out_ready;
   logic                drain_busy;
   logic                err_bad_ch;
   logic [15:0]         issued_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mq [NCH][$];
   bit          m_drain = 0;
   bit          m_bad   = 0;
   logic [15:0] m_issued = '0;

   always #5 clk = ~clk;

   pulse_issue_queue #(.NUM_CH(NCH), .DEPTH(DEP), .QOPCODE(QOP)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_instr   (in_instr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_instr  (out_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .drain_busy (drain_busy),
      .err_bad_ch (err_bad_ch),
      .issued_cnt (issued_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] pulse(input int ch, input int tag);
      return {12'(tag), 5'(ch), 3'b000, 5'b00000, QOP};
   endfunction

   function automatic bit m_all_empty();
      for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_ready();
      int chi = int'(in_instr[19:15]);
      bit q   = (in_instr[6:0] == QOP);
      if (m_drain) return m_all_empty() ? in_valid : 1'b0;
      if (q && in_instr[14:12] == 3'd0) begin
         if (chi < NCH) return mq[chi].size() != DEP;
         return 1'b1;
      end
      if (q && in_instr[14:12] == 3'd1) return m_all_empty();
      return 1'b1;
   endfunction

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         for (int c = 0; c < NCH; c++) mq[c].delete();
         m_drain  = 0;
         m_bad    = 0;
         m_issued = '0;
      end else begin
         bit hs, empty0, is_p, is_b;
         int chi;
         hs     = in_valid && m_ready();
         empty0 = m_all_empty();
         chi    = int'(in_instr[19:15]);
         is_p   = (in_instr[6:0] == QOP) && (in_instr[14:12] == 3'd0);
         is_b   = (in_instr[6:0] == QOP) && (in_instr[14:12] == 3'd1);
         for (int c = 0; c < NCH; c++) begin
            if (mq[c].size() != 0 && out_ready[c]) begin
               void'(mq[c].pop_front());
               m_issued++;
            end
         end
         if (!m_drain) begin
            if (hs && is_p) begin
               if (chi < NCH) mq[chi].push_back(in_instr);
               else m_bad = 1;
            end
            if (in_valid && is_b && !empty0) m_drain = 1;
         end else if (empty0) begin
            m_drain = 0;
         end
      end
   end

   initial forever begin
      logic [32*NCH-1:0] e_instr;
      logic [NCH-1:0]    e_valid;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         e_valid[c]          = (mq[c].size() != 0);
         e_instr[32*c +: 32] = e_valid[c] ? mq[c][0] : 32'h0;
      end
      chk("in_ready", 128'(in_ready), 128'(m_ready()));
      chk("out_valid", 128'(out_valid), 128'(e_valid));
      chk("out_instr", 128'(out_instr), 128'(e_instr));
      chk("drain_busy", 128'(drain_busy), 128'(m_drain));
      chk("err_bad_ch", 128'(err_bad_ch), 128'(m_bad));
      chk("issued_cnt", 128'(issued_cnt), 128'(m_issued));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = '0;
      tick(2);
      chk("rst_out_valid", 128'(out_valid), 128'h0);
      chk("rst_issued", 128'(issued_cnt), 128'h0);
      chk("rst_drain", 128'(drain_busy), 128'h0);
      in_instr = pulse(2, 0);
      in_valid = 1'b1;
      #1 chk("rst_in_ready", 128'(in_ready), 128'h1);
      tick(1);
      chk("rst_no_push", 128'(out_valid), 128'h0);
      reset = 1'b0;

      // Fill channel 2, fifth push must stall
      tick(1);
      for (int k = 1; k < 4; k++) begin
         in_instr = pulse(2, k);
         tick(1);
      end
      in_instr = pulse(2, 4);
      #1 chk("full_in_ready", 128'(in_ready), 128'h0);
      chk("full_out_valid", 128'(out_valid), 128'h4);
      tick(1);
      chk("full_hold", 128'(out_valid), 128'h4);

      out_ready = 4'b0100;
      #1 chk("full_pop_same_cycle", 128'(in_ready), 128'h0);
      tick(1);
      out_ready = '0;
      chk("one_pop_issued", 128'(issued_cnt), 128'h1);
      #1 chk("after_pop_ready", 128'(in_ready), 128'h1);
      tick(1);
      in_valid = 1'b0;
      chk("ch2_head", 128'(out_instr[95:64]), 128'(pulse(2, 1)));
      out_ready = 4'hF;
      tick(4);
      out_ready = '0;
      chk("ch2_drained_issued", 128'(issued_cnt), 128'd5);

      in_instr = 32'h0000_0013;
      in_valid = 1'b1;
      #1 chk("nonq_ready", 128'(in_ready), 128'h1);
      tick(1);
      in_instr = 32'h0000_200B;
      tick(1);
      in_valid = 1'b0;
      chk("nonq_no_state", 128'(out_valid), 128'h0);

      // Barrier waits for channels 0 and 3
      in_valid = 1'b1;
      in_instr = pulse(0, 5);
      tick(1);
      in_instr = pulse(3, 6);
      tick(1);
      in_instr = BAR;
      #1 chk("bar_idle_ready", 128'(in_ready), 128'h0);
      tick(1);
      chk("bar_drain_busy", 128'(drain_busy), 128'h1);
      chk("bar_valid", 128'(out_valid), 128'h9);
      tick(1);
      out_ready = 4'hF;
      #1 chk("bar_still_blocked", 128'(in_ready), 128'h0);
      tick(1);
      chk("bar_emptied", 128'(out_valid), 128'h0);
      #1 chk("bar_consume_ready", 128'(in_ready), 128'h1);
      chk("bar_busy_last", 128'(drain_busy), 128'h1);
      tick(1);
      chk("bar_done", 128'(drain_busy), 128'h0);
      chk("bar_issued", 128'(issued_cnt), 128'd7);
      in_valid  = 1'b0;
      out_ready = '0;

      in_instr = pulse(7, 9);
      in_valid = 1'b1;
      #1 chk("badch_ready", 128'(in_ready), 128'h1);
      tick(1);
      in_valid = 1'b0;
      chk("badch_no_valid", 128'(out_valid), 128'h0);
      chk("badch_err", 128'(err_bad_ch), 128'h1);
      tick(3);
      chk("badch_sticky", 128'(err_bad_ch), 128'h1);

      // Streaming through channel 1 wraps both pointers
      out_ready = 4'b0010;
      in_valid  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_instr = pulse(1, 16 + k);
         tick(1);
         chk("stream_head", 128'(out_instr[63:32]), 128'(pulse(1, 16 + k)));
      end
      in_valid = 1'b0;
      tick(2);
      chk("stream_issued", 128'(issued_cnt), 128'd13);
      out_ready = '0;

      in_valid = 1'b1;
      in_instr = pulse(0, 30);
      tick(1);
      in_instr = BAR;
      tick(1);
      in_valid = 1'b0;
      chk("drop_valid_busy", 128'(drain_busy), 128'h1);
      out_ready = 4'h1;
      tick(2);
      chk("drop_valid_idle", 128'(drain_busy), 128'h0);
      out_ready = '0;

      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_instr = pulse(3, 40 + k);
         tick(1);
      end
      in_instr = BAR;
      tick(1);
      chk("rst_drain_busy_pre", 128'(drain_busy), 128'h1);
      chk("rst_valid_pre", 128'(out_valid), 128'h8);
      reset = 1'b1;
      #1 chk("rst_mid_valid", 128'(out_valid), 128'h0);
      chk("rst_mid_drain", 128'(drain_busy), 128'h0);
      chk("rst_mid_issued", 128'(issued_cnt), 128'h0);
      chk("rst_mid_instr", 128'(out_instr), 128'h0);
      in_valid = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(2);
      chk("post_rst_valid", 128'(out_valid), 128'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_issue_queue.md
PULSE_ISSUE_QUEUE -- requirements
Module: pulse_issue_queue

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of pulse channels (1..16).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning per-channel FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have parameter QOPCODE, default 7'b0001011, meaning the quantum opcode in instr[6:0].
REQ-004 Port: clk  input  1  clock; all state on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: in_instr  input  32  instruction from the decode stage.
REQ-007 Port: in_valid  input  1  in_instr is valid.
REQ-008 Port: in_ready  output  1  the block consumes in_instr this cycle; the core stalls decode when low.
REQ-009 Port: out_instr  output  32*NUM_CH  per-channel head entry; channel c is at bits [32c+31:32c].
REQ-010 Port: out_valid  output  NUM_CH  channel c head is valid.
REQ-011 Port: out_ready  input  NUM_CH  the async FIFO for channel c accepts the head.
REQ-012 Port: drain_busy  output  1  a barrier is waiting for all queues to empty.
REQ-013 Port: err_bad_ch  output  1  sticky flag: a pulse addressed a channel >= NUM_CH.
REQ-014 Port: issued_cnt  output  16  total pulses popped across all channels.

Function
REQ-015 Decode: a quantum instruction has instr[6:0]==QOPCODE; funct3=instr[14:12]; 3'b000 is a pulse, 3'b001 is a barrier; channel index is instr[19:15].
REQ-016 Non-quantum instruction, or quantum with any other funct3: in_ready=1, the instruction is consumed and no state changes.
REQ-017 Pulse with channel < NUM_CH: in_ready = (count[ch] != DEPTH); on handshake the instruction is written at wr_ptr[ch], and wr_ptr and count increment.
REQ-018 Pulse with channel >= NUM_CH: in_ready=1, the instruction is dropped, and err_bad_ch is set to 1 from the next cycle until reset.
REQ-019 Full-channel rule: in_ready is computed from the registered count only; a same-cycle pop on a full channel does not make it ready.
REQ-020 Pop: on out_valid[c] && out_ready[c], rd_ptr[c] and count[c] decrement/advance accordingly, and issued_cnt increments by one per popped channel.
REQ-021 issued_cnt wraps modulo 2^16 and may increase by up to NUM_CH in one cycle.
REQ-022 out_valid[c] = (count[c] != 0); out_instr[c] = mem[c][rd_ptr[c]]; both are registered-state driven with no combinational path from in_*.
REQ-023 Latency: a pulse accepted at edge N appears on out_valid/out_instr after edge N, i.e. one cycle later.
REQ-024 Simultaneous push and pop on the same non-full, non-empty channel: count is unchanged and both pointers advance.
REQ-025 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-026 FSM states are IDLE and DRAIN.
REQ-027 In IDLE, a barrier with all counts zero: in_ready=1, the barrier is consumed, and the FSM stays in IDLE.
REQ-028 In IDLE, a valid barrier with any count nonzero: in_ready=0, and the FSM goes to DRAIN.
REQ-029 In DRAIN: drain_busy=1 and in_ready=0 for all inputs, while pops continue.
REQ-030 In DRAIN, when all counts are zero: in_ready=1 if in_valid is high, the barrier is consumed, and the FSM returns to IDLE.
REQ-031 If in_valid drops while in DRAIN, the FSM returns to IDLE once all counts are zero.

Reset
REQ-032 While reset is high: all counts and pointers are 0; FSM=IDLE; out_valid=0; out_instr=0; drain_busy=0; err_bad_ch=0; issued_cnt=0.
REQ-033 in_ready follows REQ-016/017 combinationally during reset; any handshake during reset is ignored.
REQ-034 Reset asserted mid-drain or with queued entries discards all entries, with no pops counted.
REQ-035 FIFO storage is not required to be reset.

Verification
REQ-036 Push pulses 0x0000_000B|ch2 (instr[19:15]=2), out_ready=0, 5 times with DEPTH=4 -> 4 accepted, then in_ready=0; out_valid=4'b0100.
REQ-037 With channel 2 full, raise out_ready[2] for one cycle -> one pop, issued_cnt=1; in_ready=1 on the following cycle.
REQ-038 Push to channels 0 and 3, then a barrier, out_ready=0 -> drain_busy=1, in_ready=0; set out_ready=4'hF -> after 1 cycle counts are 0, the barrier is consumed, and drain_busy=0 the cycle after.
REQ-039 Push a pulse with instr[19:15]=7 at NUM_CH=4 -> in_ready=1, no out_valid, err_bad_ch=1 until reset.
REQ-040 Push 6 pulses to channel 1 with out_ready[1]=1 continuously -> wrap exercised, order preserved, issued_cnt=6.
REQ-041 Assert reset with 3 entries queued in DRAIN -> out_valid=0, drain_busy=0, issued_cnt=0 immediately.
